vga_frame_scanout: RTL



---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_frame_scanout_if.sv | 26 ++
 rtl/fb_ram.sv | 30 +++
 rtl/vga_frame_scanout.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, 640x480@60 timing constants and helpers for the frame scanout block
package vga_pkg;

  localparam int CLK_DIV  = 2;
  localparam int SRC_W    = 320;
  localparam int SRC_H    = 240;
  localparam int FB_DEPTH = SRC_W * SRC_H;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef logic [2:0]  pixel_t;
  typedef logic [16:0] fb_addr_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Row stride of 320 built from two shifts: y*320 = (y<<8) + (y<<6).
  function automatic fb_addr_t scan_addr(logic [9:0] h, logic [9:0] v);
    fb_addr_t row;
    fb_addr_t col;
    row = fb_addr_t'(v >> 1);
    col = fb_addr_t'(h >> 1);
    return (row << 8) + (row << 6) + col;
  endfunction

  function automatic logic [11:0] expand_rgb(pixel_t p);
    return {{4{p[2]}}, {4{p[1]}}, {4{p[0]}}};
  endfunction

endpackage

// File: rtl/vga_frame_scanout_if.sv
// rtl/vga_frame_scanout_if.sv - pixel write port and VGA pin bundle between loader, scanout and display
interface vga_frame_scanout_if;
  import vga_pkg::*;

  pixel_t     i_data;
  fb_addr_t   i_addr;
  logic       i_we;
  logic       i_flush;
  logic       o_vga_hs;
  logic       o_vga_vs;
  logic [3:0] VGA_R;
  logic [3:0] VGA_G;
  logic [3:0] VGA_B;
  logic       o_frame_start;

  modport master (
    output i_data, i_addr, i_we, i_flush,
    input  o_vga_hs, o_vga_vs, VGA_R, VGA_G, VGA_B, o_frame_start
  );

  modport slave (
    input  i_data, i_addr, i_we, i_flush,
    output o_vga_hs, o_vga_vs, VGA_R, VGA_G, VGA_B, o_frame_start
  );

endinterface

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - simple dual-port framebuffer, one write port and one registered read port
module fb_ram
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic     i_clk,
  input  logic     i_we,
  input  fb_addr_t i_wr_addr,
  input  pixel_t   i_wr_data,
  input  fb_addr_t i_rd_addr,
  output pixel_t   o_rd_data
);

  pixel_t mem [DEPTH];
  pixel_t rd_q;

  // Same-address read and write in one clock returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_we && (i_wr_addr < fb_addr_t'(DEPTH))) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_addr < fb_addr_t'(DEPTH)) begin
      rd_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_q;

endmodule

// File: rtl/vga_frame_scanout.sv
// rtl/vga_frame_scanout.sv - 640x480 VGA timing with 2x2 replicated scanout of a 320x240 framebuffer
module vga_frame_scanout
  import vga_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_SYN   = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_SYN   = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input logic                i_clk,
  input logic                i_reset,
  vga_frame_scanout_if.slave vif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST    = 10'(H_ACT + H_FRONT + H_SYN + H_BACK - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_ACT);
  localparam logic [9:0] HS_BEG    = 10'(H_ACT + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_ACT + H_FRONT + H_SYN);
  localparam logic [9:0] V_LAST    = 10'(V_ACT + V_FRONT + V_SYN + V_BACK - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACT);
  localparam logic [9:0] VS_BEG    = 10'(V_ACT + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_ACT + V_FRONT + V_SYN);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             fs_q, fs_d;
  scan_state_t      state_q, state_d;
  fb_addr_t         addr_s1_q, addr_s1_d;
  logic             act_s1_q, act_s1_d;
  logic             act_s2_q, act_s2_d;
  logic             hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d, hs_q, hs_d;
  logic             vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_q, vs_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             pix_en;
  logic             active;
  pixel_t           rd_data;

  fb_ram #(
    .DEPTH(FB_DEPTH)
  ) u_fb_ram (
    .i_clk    (i_clk),
    .i_we     (vif.i_we),
    .i_wr_addr(vif.i_addr),
    .i_wr_data(vif.i_data),
    .i_rd_addr(addr_s1_q),
    .o_rd_data(rd_data)
  );

  always_comb begin
    pix_en = (div_q == DIV_LAST);
    div_d  = pix_en ? '0 : div_q + DIV_W'(1);

    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end

    // Fires once, on the first system clock of the h=0,v=0 pixel.
    fs_d = (h_q == '0) && (v_q == '0) && (div_q == '0);

    // Flush is only looked at on frame start so a frame is never torn.
    state_d = state_q;
    if (fs_q) begin
      state_d = vif.i_flush ? SHOW : BLANK;
    end

    active    = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    addr_s1_d = scan_addr(h_q, v_q);
    act_s1_d  = active;
    act_s2_d  = act_s1_q;
    hs_s1_d   = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_s1_d   = !((v_q >= VS_BEG) && (v_q < VS_END));
    hs_s2_d   = hs_s1_q;
    vs_s2_d   = vs_s1_q;
    hs_d      = hs_s2_q;
    vs_d      = vs_s2_q;
    rgb_d     = (act_s2_q && (state_q == SHOW)) ? expand_rgb(rd_data) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      fs_q      <= 1'b0;
      state_q   <= BLANK;
      addr_s1_q <= '0;
      act_s1_q  <= 1'b0;
      act_s2_q  <= 1'b0;
      hs_s1_q   <= 1'b1;
      hs_s2_q   <= 1'b1;
      hs_q      <= 1'b1;
      vs_s1_q   <= 1'b1;
      vs_s2_q   <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= '0;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      fs_q      <= fs_d;
      state_q   <= state_d;
      addr_s1_q <= addr_s1_d;
      act_s1_q  <= act_s1_d;
      act_s2_q  <= act_s2_d;
      hs_s1_q   <= hs_s1_d;
      hs_s2_q   <= hs_s2_d;
      hs_q      <= hs_d;
      vs_s1_q   <= vs_s1_d;
      vs_s2_q   <= vs_s2_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vif.o_vga_hs      = hs_q;
  assign vif.o_vga_vs      = vs_q;
  assign vif.VGA_R         = rgb_q[11:8];
  assign vif.VGA_G         = rgb_q[7:4];
  assign vif.VGA_B         = rgb_q[3:0];
  assign vif.o_frame_start = fs_q;

endmodule
